audio_deserializer: RTL and testbench
=====================================

// Module: audio_deserializer
// PURPOSE
//  Receive side of the 1-bit serial audio link: samples audio_data_in MSB-first
//  on each bit_strobe and assembles WIDTH-bit words. Each word goes into a small
//  first-word-fall-through FIFO, which presents it on a valid/ready port with a
//  wrapping memory write address. Sits between the serial audio pin and the
//  sample memory writer.
// PARAMETERS
//  WIDTH       16  bits per word; first received bit lands in word_out[WIDTH-1]
//  FIFO_DEPTH  4   output buffer entries (power of 2, >=2)
//  ADDR_WIDTH  16  width of word_addr
//  ADDR_LAST   255 last address used; the address counter wraps from here to 0
// PORTS
//  clock          in   1           rising-edge clock
//  reset_n        in   1           asynchronous, active-low reset
//  enable         in   1           receive enable; low = idle, partial word discarded
//  bit_strobe     in   1           audio_data_in is valid this cycle
//  audio_data_in  in   1           serial data, MSB first
//  word_out       out  WIDTH       FIFO head word
//  word_addr      out  ADDR_WIDTH  memory address for the FIFO head word
//  word_valid     out  1           FIFO not empty
//  word_ready     in   1           consumer accepts the head word (pop when valid&&ready)
//  done           out  1           one-cycle pulse per completed word (pushed or dropped)
//  overflow       out  1           sticky: a word was dropped because the FIFO was full
//  clear_overflow in   1           synchronous clear of overflow
//  fill_level     out  log2(D)+1   number of FIFO entries
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, shift register=0, bit_cnt=0, FIFO empty,
//   address counter=0. Outputs: word_out=0, word_addr=0, word_valid=0, done=0,
//   overflow=0, fill_level=0.
//  FSM IDLE: bit_cnt=0, shift reg held at 0. Go to RECV when enable=1; strobes in
//   the IDLE->RECV cycle are ignored.
//  FSM RECV: on each bit_strobe, shreg<={shreg[WIDTH-2:0],audio_data_in} and
//   bit_cnt++.
//   - When a strobe arrives with bit_cnt==WIDTH-1: the word
//     {shreg[WIDTH-2:0],audio_data_in} is pushed, bit_cnt->0, and done=1 in the
//     next cycle only.
//   - enable=0 in any cycle: go to IDLE, clear bit_cnt and shreg, and discard the
//     partial word. FIFO contents, overflow and the address counter are kept; the
//     FIFO still drains while idle.
//  Latency: a word whose last bit is strobed at edge N has word_valid=1 after
//   edge N, provided the FIFO was empty.
//  FIFO:
//   - word_out and word_addr always show the head entry.
//   - Push and pop in the same cycle are legal at any fill level, including full;
//     fill_level is then unchanged.
//   - Push while full with no pop: the word is dropped, overflow<=1, done still
//     pulses.
//   - clear_overflow and a new drop in the same cycle: the set wins.
//   - Contents of an empty FIFO are don't-care, but word_out=0 while word_valid=0.
//  Address: the counter is captured into the FIFO entry on push, then incremented.
//   After ADDR_LAST it wraps to 0. Dropped words do not advance it. enable does not
//   reset it.
//  Reset mid-word or mid-drain: everything returns to reset values immediately;
//   there is no partial output.
// TESTING
//  1 Strobe every cycle, bits of 16'hA5C3 MSB first, word_ready=1 -> word_out=A5C3,
//    word_addr=0, word_valid for 1 cycle, done exactly one pulse the cycle after
//    bit 16.
//  2 Strobe every 3rd cycle, words 1234,ABCD -> same values, addresses 0,1; bits
//    from non-strobe cycles ignored.
//  3 word_ready=0, 5 words -> fill_level=4, 5th word dropped, overflow=1, 5 done
//    pulses; drain yields the first 4 in order at addresses 0-3; clear_overflow->0.
//  4 FIFO full, push and pop in the same cycle -> no drop, overflow stays 0,
//    fill_level stays 4.
//  5 enable low after 7 bits of 16'hFFFF, then re-enabled with 16'h0F0F -> only
//    0F0F appears, no done for the partial word; the same check with reset_n
//    pulsed low mid-word.
//  6 ADDR_LAST=3, 6 words with ready=1 -> addresses 0,1,2,3,0,1.

Source files
------------

// File: rtl/audio_deserializer.sv
// Serial audio receiver: assembles MSB-first bits into WIDTH-bit words and
// buffers them in a first-word-fall-through FIFO tagged with wrapping addresses.
module audio_deserializer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ADDR_LAST  = 255
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic                          bit_strobe,
  input  logic                          audio_data_in,
  output logic [WIDTH-1:0]              word_out,
  output logic [ADDR_WIDTH-1:0]         word_addr,
  output logic                          word_valid,
  input  logic                          word_ready,
  output logic                          done,
  output logic                          overflow,
  input  logic                          clear_overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned BIT_W = $clog2(WIDTH);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RECV = 1'b1
  } state_t;

  state_t                  state;
  // The first bit shifted in ends up as the MSB once the final bit is appended.
  logic [WIDTH-2:0]        shreg;
  logic [BIT_W-1:0]        bit_cnt;

  logic [WIDTH-1:0]        mem_word [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]   mem_addr [FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr;
  logic [PTR_W-1:0]        rd_ptr;
  logic [CNT_W-1:0]        count;
  logic [ADDR_WIDTH-1:0]   addr_cnt;

  logic                    push_c;
  logic                    pop_c;
  logic                    full_c;
  logic                    accept_c;
  logic                    drop_c;
  logic [WIDTH-1:0]        word_c;

  // Word completion and FIFO handshake decode
  always_comb begin
    push_c   = (state == S_RECV) && enable && bit_strobe &&
               (bit_cnt == BIT_W'(WIDTH - 1));
    word_c   = {shreg, audio_data_in};
    pop_c    = (count != '0) && word_ready;
    full_c   = (count == CNT_W'(FIFO_DEPTH));
    accept_c = push_c && (!full_c || pop_c);
    drop_c   = push_c && full_c && !pop_c;
  end

  // Receive FSM and shift register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          shreg   <= '0;
          bit_cnt <= '0;
          if (enable) state <= S_RECV;
        end
        S_RECV: begin
          if (!enable) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
          end else if (bit_strobe) begin
            shreg   <= word_c[WIDTH-2:0];
            bit_cnt <= push_c ? '0 : bit_cnt + BIT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // FIFO storage, pointers, address counter and status flags
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        mem_word[i] <= '0;
        mem_addr[i] <= '0;
      end
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (accept_c) begin
        mem_word[wr_ptr] <= word_c;
        mem_addr[wr_ptr] <= addr_cnt;
        wr_ptr           <= wr_ptr + PTR_W'(1);
        addr_cnt         <= (addr_cnt == ADDR_WIDTH'(ADDR_LAST)) ? '0
                                                                 : addr_cnt + ADDR_WIDTH'(1);
      end
      if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({accept_c, pop_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      done <= push_c;
      if (drop_c)              overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

  // Head of FIFO is presented directly; zeroed while empty
  always_comb begin
    fill_level = count;
    word_valid = (count != '0);
    word_out   = word_valid ? mem_word[rd_ptr] : '0;
    word_addr  = word_valid ? mem_addr[rd_ptr] : '0;
  end

endmodule

// File: tb/tb_audio_deserializer.sv
// Directed self-checking bench for audio_deserializer; a second instance with
// ADDR_LAST=3 exercises address wrap.
module tb_audio_deserializer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        en2 = 1'b0;
  logic        bit_strobe = 1'b0;
  logic        audio_data_in = 1'b0;
  logic        word_ready = 1'b0;
  logic        ready2 = 1'b1;
  logic        clear_overflow = 1'b0;
  logic        clear2 = 1'b0;

  logic [15:0] word_out, word_out2;
  logic [15:0] word_addr, word_addr2;
  logic        word_valid, word_valid2;
  logic        done, done2;
  logic        overflow, overflow2;
  logic [2:0]  fill_level, fill_level2;

  int n_pass = 0;
  int n_total = 0;
  int done_cnt = 0;
  int done2_cnt = 0;

  always #5 clock = ~clock;

  audio_deserializer #(.WIDTH(16), .FIFO_DEPTH(4), .ADDR_WIDTH(16), .ADDR_LAST(255)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .bit_strobe(bit_strobe),
    .audio_data_in(audio_data_in), .word_out(word_out), .word_addr(word_addr),
    .word_valid(word_valid), .word_ready(word_ready), .done(done),
    .overflow(overflow), .clear_overflow(clear_overflow), .fill_level(fill_level));

  audio_deserializer #(.WIDTH(16), .FIFO_DEPTH(4), .ADDR_WIDTH(16), .ADDR_LAST(3)) dut_wrap (
    .clock(clock), .reset_n(reset_n), .enable(en2), .bit_strobe(bit_strobe),
    .audio_data_in(audio_data_in), .word_out(word_out2), .word_addr(word_addr2),
    .word_valid(word_valid2), .word_ready(ready2), .done(done2),
    .overflow(overflow2), .clear_overflow(clear2), .fill_level(fill_level2));

  always @(negedge clock) begin
    if (done === 1'b1)  done_cnt++;
    if (done2 === 1'b1) done2_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bits in the gap cycles carry the inverted value so a wrongly sampled bit shows up.
  task automatic send_bit(input logic b, input int gap);
    repeat (gap) begin
      audio_data_in = ~b;
      tick();
    end
    bit_strobe    = 1'b1;
    audio_data_in = b;
    tick();
    bit_strobe    = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    for (int i = 15; i >= 0; i--) send_bit(w[i], gap);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; en2 = 1'b0; bit_strobe = 1'b0;
    word_ready = 1'b0; clear_overflow = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic start_rx();
    enable = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #2;
    n_total++; if (word_out !== 16'h0) $display("FAIL rst_word got %h exp 0000", word_out); else n_pass++;
    n_total++; if (word_addr !== 16'h0) $display("FAIL rst_addr got %h exp 0000", word_addr); else n_pass++;
    n_total++; if (word_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", word_valid); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL rst_done got %b exp 0", done); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %b exp 0", overflow); else n_pass++;
    n_total++; if (fill_level !== 3'd0) $display("FAIL rst_fill got %0d exp 0", fill_level); else n_pass++;
    do_reset();
  endtask

  task automatic test_single_word();
    logic [15:0] w;
    int d0;
    w = 16'hA5C3;
    do_reset();
    word_ready = 1'b1;
    start_rx();
    d0 = done_cnt;
    for (int i = 15; i >= 1; i--) send_bit(w[i], 0);
    n_total++; if (word_valid !== 1'b0) $display("FAIL t1_early_valid got %b exp 0", word_valid); else n_pass++;
    n_total++; if (done_cnt !== d0) $display("FAIL t1_early_done got %0d exp %0d", done_cnt, d0); else n_pass++;
    send_bit(w[0], 0);
    n_total++; if (word_valid !== 1'b1) $display("FAIL t1_valid got %b exp 1", word_valid); else n_pass++;
    n_total++; if (word_out !== 16'hA5C3) $display("FAIL t1_word got %h exp a5c3", word_out); else n_pass++;
    n_total++; if (word_addr !== 16'd0) $display("FAIL t1_addr got %0d exp 0", word_addr); else n_pass++;
    n_total++; if (done !== 1'b1) $display("FAIL t1_done got %b exp 1", done); else n_pass++;
    tick();
    n_total++; if (word_valid !== 1'b0) $display("FAIL t1_valid_after got %b exp 0", word_valid); else n_pass++;
    n_total++; if (word_out !== 16'h0) $display("FAIL t1_word_empty got %h exp 0000", word_out); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL t1_done_after got %b exp 0", done); else n_pass++;
    n_total++; if (done_cnt !== d0 + 1) $display("FAIL t1_done_count got %0d exp %0d", done_cnt, d0 + 1); else n_pass++;
  endtask

  task automatic test_sparse_strobe();
    do_reset();
    word_ready = 1'b1;
    start_rx();
    send_word(16'h1234, 2);
    n_total++; if (word_out !== 16'h1234) $display("FAIL t2_word0 got %h exp 1234", word_out); else n_pass++;
    n_total++; if (word_addr !== 16'd0) $display("FAIL t2_addr0 got %0d exp 0", word_addr); else n_pass++;
    send_word(16'hABCD, 2);
    n_total++; if (word_out !== 16'hABCD) $display("FAIL t2_word1 got %h exp abcd", word_out); else n_pass++;
    n_total++; if (word_addr !== 16'd1) $display("FAIL t2_addr1 got %0d exp 1", word_addr); else n_pass++;
  endtask

  task automatic test_overflow();
    logic [15:0] exp_w [5];
    int d0;
    exp_w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    do_reset();
    start_rx();
    d0 = done_cnt;
    for (int k = 0; k < 4; k++) send_word(exp_w[k], 0);
    n_total++; if (fill_level !== 3'd4) $display("FAIL t3_fill4 got %0d exp 4", fill_level); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL t3_ovf_before got %b exp 0", overflow); else n_pass++;
    send_word(exp_w[4], 0);
    tick();
    n_total++; if (fill_level !== 3'd4) $display("FAIL t3_fill_drop got %0d exp 4", fill_level); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL t3_ovf got %b exp 1", overflow); else n_pass++;
    n_total++; if (done_cnt !== d0 + 5) $display("FAIL t3_done_count got %0d exp %0d", done_cnt, d0 + 5); else n_pass++;
    word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (word_out !== exp_w[k]) $display("FAIL t3_drain_word%0d got %h exp %h", k, word_out, exp_w[k]); else n_pass++;
      n_total++; if (word_addr !== 16'(k)) $display("FAIL t3_drain_addr%0d got %0d exp %0d", k, word_addr, k); else n_pass++;
      tick();
    end
    n_total++; if (word_valid !== 1'b0) $display("FAIL t3_empty got %b exp 0", word_valid); else n_pass++;
    n_total++; if (overflow !== 1'b1) $display("FAIL t3_ovf_sticky got %b exp 1", overflow); else n_pass++;
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    n_total++; if (overflow !== 1'b0) $display("FAIL t3_ovf_clear got %b exp 0", overflow); else n_pass++;
  endtask

  task automatic test_full_push_pop();
    logic [15:0] exp_w [5];
    exp_w = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'hBEEF};
    do_reset();
    start_rx();
    for (int k = 0; k < 4; k++) send_word(exp_w[k], 0);
    for (int i = 15; i >= 1; i--) send_bit(exp_w[4][i], 0);
    word_ready = 1'b1;
    send_bit(exp_w[4][0], 0);
    word_ready = 1'b0;
    n_total++; if (fill_level !== 3'd4) $display("FAIL t4_fill got %0d exp 4", fill_level); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL t4_ovf got %b exp 0", overflow); else n_pass++;
    word_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      n_total++; if (word_out !== exp_w[k]) $display("FAIL t4_drain_word%0d got %h exp %h", k, word_out, exp_w[k]); else n_pass++;
      n_total++; if (word_addr !== 16'(k)) $display("FAIL t4_drain_addr%0d got %0d exp %0d", k, word_addr, k); else n_pass++;
      tick();
    end
    n_total++; if (word_valid !== 1'b0) $display("FAIL t4_empty got %b exp 0", word_valid); else n_pass++;
  endtask

  task automatic test_abort();
    int d0;
    do_reset();
    word_ready = 1'b1;
    start_rx();
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    n_total++; if (done_cnt !== d0) $display("FAIL t5_partial_done got %0d exp %0d", done_cnt, d0); else n_pass++;
    send_word(16'h0F0F, 0);
    n_total++; if (word_out !== 16'h0F0F) $display("FAIL t5_word got %h exp 0f0f", word_out); else n_pass++;
    n_total++; if (word_addr !== 16'd0) $display("FAIL t5_addr got %0d exp 0", word_addr); else n_pass++;
    tick();
    n_total++; if (done_cnt !== d0 + 1) $display("FAIL t5_done_count got %0d exp %0d", done_cnt, d0 + 1); else n_pass++;
    n_total++; if (word_valid !== 1'b0) $display("FAIL t5_valid_after got %b exp 0", word_valid); else n_pass++;
    // Same scenario, but abort the partial word with an asynchronous reset pulse.
    send_word(16'h7777, 0);
    tick();
    d0 = done_cnt;
    for (int i = 0; i < 7; i++) send_bit(1'b1, 0);
    reset_n = 1'b0;
    #2;
    n_total++; if (fill_level !== 3'd0) $display("FAIL t5_rst_fill got %0d exp 0", fill_level); else n_pass++;
    tick();
    reset_n = 1'b1;
    tick();
    send_word(16'h0F0F, 0);
    n_total++; if (word_out !== 16'h0F0F) $display("FAIL t5_rst_word got %h exp 0f0f", word_out); else n_pass++;
    n_total++; if (word_addr !== 16'd0) $display("FAIL t5_rst_addr got %0d exp 0", word_addr); else n_pass++;
    tick();
    n_total++; if (done_cnt !== d0 + 1) $display("FAIL t5_rst_done_count got %0d exp %0d", done_cnt, d0 + 1); else n_pass++;
  endtask

  task automatic test_addr_wrap();
    logic [15:0] w;
    do_reset();
    en2 = 1'b1;
    tick();
    for (int k = 0; k < 6; k++) begin
      w = 16'hC000 + 16'(k);
      send_word(w, 0);
      n_total++; if (word_out2 !== w) $display("FAIL t6_word%0d got %h exp %h", k, word_out2, w); else n_pass++;
      n_total++; if (word_addr2 !== 16'(k % 4)) $display("FAIL t6_addr%0d got %0d exp %0d", k, word_addr2, k % 4); else n_pass++;
    end
    n_total++; if (word_valid !== 1'b0) $display("FAIL t6_main_idle got %b exp 0", word_valid); else n_pass++;
    en2 = 1'b0;
  endtask

  initial begin
    tick();
    test_reset();
    test_single_word();
    test_sparse_strobe();
    test_overflow();
    test_full_push_pop();
    test_abort();
    test_addr_wrap();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
